// File: rtl/multi_user_free_queue_if.sv
// Handshake bundle between the free-pointer queue and its users: pointer return
// and pop strobes in, head pointer and occupancy status out.
interface multi_user_free_queue_if #(
  parameter int DEPTH = 512,
  parameter int PTR_W = 10
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [15:0]      ptr_din;
  logic             FQ_wr;
  logic             FQ_rd;
  logic [PTR_W-1:0] ptr_dout_s;
  logic             ptr_fifo_empty;
  logic             FQ_act;
  logic [CNT_W-1:0] FQ_count;

  modport master (
    output ptr_din, FQ_wr, FQ_rd,
    input  ptr_dout_s, ptr_fifo_empty, FQ_act, FQ_count
  );

  modport slave (
    input  ptr_din, FQ_wr, FQ_rd,
    output ptr_dout_s, ptr_fifo_empty, FQ_act, FQ_count
  );
endinterface

// File: rtl/multi_user_free_queue.sv
// Free-pointer queue for the shared cell buffer: self-fills with 0..DEPTH-1 after
// reset, then serves as a show-ahead FIFO of free pointers with occupancy count.
module multi_user_free_queue #(
  parameter int DEPTH = 512,
  parameter int PTR_W = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  multi_user_free_queue_if.slave  fq
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {S_INIT, S_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [PTR_W-1:0] mem_wdata;
  logic             do_rd, do_wr;
  logic             empty, full;
  logic             unused_din_hi;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Returned pointers carry spare upper bits that are never stored.
  assign unused_din_hi = ^fq.ptr_din[15:PTR_W];

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    init_cnt_d = init_cnt_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    mem_wdata  = fq.ptr_din[PTR_W-1:0];
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_wdata  = PTR_W'(init_cnt_q);
        wr_idx_d   = wr_idx_q + IDX_W'(1);
        init_cnt_d = init_cnt_q + IDX_W'(1);
        count_d    = count_q + CNT_W'(1);
        if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // Full/empty guards use the pre-edge count; a push into an empty queue
        // with a simultaneous pop keeps the pushed value.
        do_rd  = fq.FQ_rd && !empty;
        do_wr  = fq.FQ_wr && !full;
        mem_we = do_wr;
        if (do_rd) rd_idx_d = rd_idx_q + IDX_W'(1);
        if (do_wr) wr_idx_d = wr_idx_q + IDX_W'(1);
        case ({do_wr, do_rd})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_INIT;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      init_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      init_cnt_q <= init_cnt_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: INIT rewrites every entry before it can be read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_idx_q] <= mem_wdata;
  end

  assign fq.ptr_dout_s     = (state_q == S_ACTIVE) ? mem_q[rd_idx_q] : '0;
  assign fq.ptr_fifo_empty = empty;
  assign fq.FQ_act         = (state_q == S_ACTIVE);
  assign fq.FQ_count       = count_q;
endmodule

// File: tb/tb_multi_user_free_queue.sv
// Scoreboard bench for multi_user_free_queue: a queue model tracks stored
// pointers; heads, occupancy and status are compared after every operation.
module tb_multi_user_free_queue;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int unsigned sb[$];

  multi_user_free_queue_if #(.DEPTH(512), .PTR_W(10)) fq ();

  multi_user_free_queue #(.DEPTH(512), .PTR_W(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fq   (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 32'(fq.FQ_count), sb.size());
    chk({tag, "_empty"}, 32'(fq.ptr_fifo_empty), (sb.size() == 0) ? 1 : 0);
    if (sb.size() > 0) chk({tag, "_head"}, 32'(fq.ptr_dout_s), sb[0]);
  endtask

  // One cycle of user activity; the model applies the same guards on the
  // pre-edge occupancy.
  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [15:0] din);
    int n;
    n = sb.size();
    if (rd && n > 0) chk({tag, "_pophead"}, 32'(fq.ptr_dout_s), sb[0]);
    fq.FQ_rd   = rd;
    fq.FQ_wr   = wr;
    fq.ptr_din = din;
    if (rd && n > 0) void'(sb.pop_front());
    if (wr && n < 512) sb.push_back(32'(din[9:0]));
    tick();
    fq.FQ_rd = 1'b0;
    fq.FQ_wr = 1'b0;
    check_status(tag);
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < 512; i++) begin
      chk({tag, "_act_low"}, 32'(fq.FQ_act), 0);
      tick();
    end
    chk({tag, "_act_high"}, 32'(fq.FQ_act), 1);
    chk({tag, "_count"}, 32'(fq.FQ_count), 512);
    chk({tag, "_empty"}, 32'(fq.ptr_fifo_empty), 0);
    chk({tag, "_dout"}, 32'(fq.ptr_dout_s), 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rstn       = 1'b0;
    fq.FQ_rd   = 1'b1;
    fq.FQ_wr   = 1'b1;
    fq.ptr_din = 16'h03FF;
    repeat (3) tick();

    chk("rst_act", 32'(fq.FQ_act), 0);
    chk("rst_count", 32'(fq.FQ_count), 0);
    chk("rst_empty", 32'(fq.ptr_fifo_empty), 1);
    chk("rst_dout", 32'(fq.ptr_dout_s), 0);

    // Power-up with rd/wr held high during INIT: they must have no effect.
    rstn = 1'b1;
    run_init("init");
    fq.FQ_rd = 1'b0;
    fq.FQ_wr = 1'b0;
    sb.delete();
    for (int i = 0; i < 512; i++) sb.push_back(i);

    // Sequential pops
    for (int i = 0; i < 3; i++) do_op("seqpop", 1'b1, 1'b0, 16'h0);
    chk("seqpop_dout3", 32'(fq.ptr_dout_s), 3);
    chk("seqpop_cnt509", 32'(fq.FQ_count), 509);

    // Simultaneous pop and push at 509
    do_op("simul", 1'b1, 1'b1, 16'h0001);
    chk("simul_cnt", 32'(fq.FQ_count), 509);

    // Fill to full, then a push that must be dropped
    do_op("fill", 1'b0, 1'b1, 16'h0100);
    do_op("fill", 1'b0, 1'b1, 16'h0101);
    do_op("fill", 1'b0, 1'b1, 16'h0102);
    chk("fill_cnt512", 32'(fq.FQ_count), 512);
    do_op("fullguard", 1'b0, 1'b1, 16'h00AA);

    // Drain completely, checking FIFO order across the index wrap
    for (int i = 0; i < 512; i++) do_op("drain", 1'b1, 1'b0, 16'h0);
    chk("drain_empty", 32'(fq.ptr_fifo_empty), 1);
    chk("drain_cnt", 32'(fq.FQ_count), 0);
    do_op("underflow", 1'b1, 1'b0, 16'h0);
    do_op("underflow2", 1'b1, 1'b0, 16'h0);

    // Refill with upper bits set on the returned pointer
    do_op("push5", 1'b0, 1'b1, 16'h0005);
    do_op("push7", 1'b0, 1'b1, 16'hFC07);
    chk("refill_cnt2", 32'(fq.FQ_count), 2);
    do_op("pop5", 1'b1, 1'b0, 16'h0);
    do_op("pop7", 1'b1, 1'b0, 16'h0);

    // Pop+push while empty: push lands, pop ignored
    do_op("emptysim", 1'b1, 1'b1, 16'h0033);
    chk("emptysim_cnt", 32'(fq.FQ_count), 1);
    do_op("emptysim_pop", 1'b1, 1'b0, 16'h0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

    // Mid-init reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (100) tick();
    chk("midinit_cnt100", 32'(fq.FQ_count), 100);
    rstn = 1'b0;
    #1;
    chk("midrst_cnt", 32'(fq.FQ_count), 0);
    chk("midrst_act", 32'(fq.FQ_act), 0);
    chk("midrst_empty", 32'(fq.ptr_fifo_empty), 1);
    tick();
    rstn = 1'b1;
    run_init("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_user_free_queue.md
# multi_user_free_queue

Free-pointer queue for the switch core's shared cell buffer. After reset it fills itself with every buffer pointer (0..511). It then hands out free pointers to the ingress writer and takes back pointers released by the egress reader once a cell's multicast count reaches zero. It also reports its occupancy so the writer can check that enough pointers exist for a whole frame before starting.

## Interface
- DEPTH, 512: number of pointers managed; also the queue capacity.
- PTR_W, 10: width of a stored pointer.
- clk  input  1: single system clock; all logic on rising edge.
- rstn  input  1: asynchronous, active-low reset.
- ptr_din  input  16: returned pointer; only bits [PTR_W-1:0] are stored, upper bits ignored.
- FQ_wr  input  1: single-cycle push of ptr_din.
- FQ_rd  input  1: single-cycle pop of the head entry.
- ptr_dout_s  output  PTR_W: current head entry (show-ahead, first-word-fall-through).
- ptr_fifo_empty  output  1: queue holds no pointers.
- FQ_act  output  1: initialisation complete; queue usable.
- FQ_count  output  10: number of stored pointers, 0..512.

## Operation
- Storage is a DEPTH x PTR_W circular buffer with 9-bit read/write indices that wrap from 511 to 0. Occupancy is tracked in a separate counter, not derived from index difference.
- **Reset:**
  - FQ_act=0, FQ_count=0, ptr_fifo_empty=1, ptr_dout_s=0.
  - Indices and the init counter are cleared.
- **INIT state** (entered on reset release):
  - Writes values 0,1,2,...,511 into consecutive entries, one per clock.
  - FQ_count increments by 1 per write.
  - FQ_wr and FQ_rd are ignored while in INIT.
- **INIT to ACTIVE:** after the 512th init write, the state goes to ACTIVE.
  - FQ_act goes to 1 and stays 1 until the next reset.
  - At this point FQ_count=512 and ptr_dout_s=0.
- **ACTIVE state:**
  - FQ_rd with !ptr_fifo_empty: advance the read index; FQ_count -1.
  - FQ_rd when empty: ignored. No index or count change, no underflow wrap.
  - FQ_wr when FQ_count<512: store ptr_din[9:0] at the write index, advance it; FQ_count +1.
  - FQ_wr when full (FQ_count=512): ignored.
  - FQ_rd and FQ_wr in the same cycle: both take effect and FQ_count is unchanged.
    - This applies even when empty: the pushed value is stored, the pop is ignored, and count becomes 1.
- **Status outputs:**
  - ptr_fifo_empty = (FQ_count==0).
  - ptr_dout_s = buffer entry at the read index. It is valid whenever !ptr_fifo_empty and undefined-but-stable when empty.

## Timing
- All outputs are registered state, or a memory read at the registered read index. None depends combinationally on FQ_rd or FQ_wr.
- **Pop:** a consumer samples ptr_dout_s in the same cycle it asserts FQ_rd. After that edge:
  - ptr_dout_s shows the next entry;
  - FQ_count and ptr_fifo_empty are updated.
- **Push:** after the edge that samples FQ_wr, FQ_count and ptr_fifo_empty are updated. If the queue was empty, ptr_dout_s shows the pushed value in the following cycle.
- **Back-to-back:** FQ_rd may be asserted on consecutive cycles; each pop returns a distinct entry in FIFO order.
- **Init length:**
  - First init write occurs at the first rising edge with rstn high.
  - FQ_act is 1 from the cycle after the 512th such edge.
- **Reset mid-operation:** asserting rstn low at any time (including during INIT) clears everything at once. On release, INIT restarts from pointer 0.

## Test plan
- **Power-up:**
  - Release rstn, then count clocks.
  - FQ_act stays 0 for 512 edges, then is 1.
  - FQ_count=512, ptr_fifo_empty=0, ptr_dout_s=0.
  - FQ_rd asserted during INIT has no effect.
- **Sequential pops:**
  - Pulse FQ_rd on 3 consecutive cycles.
  - Sampled heads are 0,1,2; ptr_dout_s then =3; FQ_count=509.
- **Drain and refill with wrap:**
  - Pop all 512; ptr_fifo_empty=1, FQ_count=0.
  - Extra FQ_rd changes nothing.
  - Push 0x005 then 0xFC07. Heads read back as 5 then 7 (upper bits dropped); FQ_count=2 after both pushes.
- **Simultaneous read/write:**
  - At FQ_count=509, assert FQ_rd and FQ_wr (ptr_din=0x001) together.
  - FQ_count stays 509; the popped head is returned and 1 is appended at the tail.
- **Full guard:** at FQ_count=512, push 0x0AA. FQ_count stays 512 and the queue order is unchanged.
- **Mid-init reset:**
  - Assert rstn low after 100 init cycles: FQ_count=0 and FQ_act=0 immediately.
  - Release: 512 more edges are needed before FQ_act=1, and ptr_dout_s=0.
